// File: rtl/mycpu_pkg.sv
// Shared types for the memory arbiter: FSM states, owner encoding and a
// counter-width helper.
package mycpu_pkg;

  typedef enum logic [1:0] {IDLE, ACC, RESP} arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } arb_owner_t;

  // Bits needed to hold the values 0..n, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating DMA starvation counter; at_limit forces the next contended grant
// to DMA. Only used when MEM_ARB_STARVE_EN is defined.
module arb_starve_cnt
  import mycpu_pkg::*;
#(
  parameter int LIM = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = cnt_w(LIM);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(LIM))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == CW'(LIM));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (CPU priority, fixed read latency).
// Define MEM_ARB_STARVE_EN to compile in the bounded DMA starvation guard.
module mem_arbiter
  import mycpu_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_in,
  input  logic          cpu_we_in,
  input  logic [AW-1:0] cpu_addr_in,
  input  logic [DW-1:0] cpu_wdata_in,
  output logic          cpu_ack_out,
  output logic [DW-1:0] cpu_rdata_out,
  input  logic          dma_req_in,
  input  logic          dma_we_in,
  input  logic [AW-1:0] dma_addr_in,
  input  logic [DW-1:0] dma_wdata_in,
  output logic          dma_ack_out,
  output logic [DW-1:0] dma_rdata_out,
  output logic          mem_en_out,
  output logic          mem_we_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in,
  output logic [1:0]    owner_out
);

  localparam int LW = cnt_w(MEM_LAT);

  arb_state_t    state;
  arb_owner_t    owner;
  logic [LW-1:0] lat;
  logic          force_dma;
  logic          cpu_win;
  logic          dma_win;

`ifdef MEM_ARB_STARVE_EN
  logic starve_inc;
  logic starve_clr;

  assign starve_inc = (state == IDLE) && dma_req_in && cpu_win;
  assign starve_clr = (state == IDLE) && dma_win;

  arb_starve_cnt #(.LIM(STARVE_LIM)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (force_dma)
  );
`else
  assign force_dma = 1'b0;
`endif

  assign cpu_win   = cpu_req_in && !(dma_req_in && force_dma);
  assign dma_win   = dma_req_in && !cpu_win;
  assign owner_out = owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      lat           <= '0;
      cpu_ack_out   <= 1'b0;
      dma_ack_out   <= 1'b0;
      cpu_rdata_out <= '0;
      dma_rdata_out <= '0;
      mem_en_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
    end else begin
      cpu_ack_out <= 1'b0;
      dma_ack_out <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_win || dma_win) begin
            state         <= ACC;
            mem_en_out    <= 1'b1;
            lat           <= LW'(MEM_LAT);
            owner         <= cpu_win ? OWN_CPU : OWN_DMA;
            mem_we_out    <= cpu_win ? cpu_we_in    : dma_we_in;
            mem_addr_out  <= cpu_win ? cpu_addr_in  : dma_addr_in;
            mem_wdata_out <= cpu_win ? cpu_wdata_in : dma_wdata_in;
          end
        end
        ACC: begin
          mem_en_out <= 1'b0;
          if (lat == '0) begin
            // Read data is valid exactly on the last ACC cycle.
            state <= RESP;
            if (!mem_we_out) begin
              if (owner == OWN_CPU) cpu_rdata_out <= mem_rdata_in;
              else                  dma_rdata_out <= mem_rdata_in;
            end
            cpu_ack_out <= (owner == OWN_CPU);
            dma_ack_out <= (owner == OWN_DMA);
          end else begin
            lat <= lat - 1'b1;
          end
        end
        RESP: begin
          // Requester still holds req here; never re-arbitrate in RESP.
          state <= IDLE;
          owner <= OWN_NONE;
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table with read-data scoreboard,
// plus contention and mid-access reset sequences.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MEM_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_in, cpu_we_in, dma_req_in, dma_we_in;
  logic [AW-1:0] cpu_addr_in, dma_addr_in, mem_addr_out;
  logic [DW-1:0] cpu_wdata_in, dma_wdata_in, mem_wdata_out, mem_rdata_in;
  logic [DW-1:0] cpu_rdata_out, dma_rdata_out;
  logic          cpu_ack_out, dma_ack_out, mem_en_out, mem_we_out;
  logic [1:0]    owner_out;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_LIM(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_in    (cpu_req_in),
    .cpu_we_in     (cpu_we_in),
    .cpu_addr_in   (cpu_addr_in),
    .cpu_wdata_in  (cpu_wdata_in),
    .cpu_ack_out   (cpu_ack_out),
    .cpu_rdata_out (cpu_rdata_out),
    .dma_req_in    (dma_req_in),
    .dma_we_in     (dma_we_in),
    .dma_addr_in   (dma_addr_in),
    .dma_wdata_in  (dma_wdata_in),
    .dma_ack_out   (dma_ack_out),
    .dma_rdata_out (dma_rdata_out),
    .mem_en_out    (mem_en_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata_in),
    .owner_out     (owner_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            dma;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  bit            sb_en = 1'b0;
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] dma_q[$];
  logic [DW-1:0] mem[256];
  logic [AW-1:0] raddr;
  int            rem = 0;
  vec_t          tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory macro model: read data is driven only for the one cycle it is valid.
  always @(negedge clk) begin
    int nrem;
    nrem = rem;
    if (nrem != 0) nrem--;
    mem_rdata_in = (rem != 0 && nrem == 0) ? mem[raddr] : 16'hDEAD;
    if (mem_en_out) begin
      if (mem_we_out) mem[mem_addr_out] = mem_wdata_out;
      else begin
        raddr = mem_addr_out;
        nrem  = MEM_LAT;
      end
    end
    rem = nrem;
  end

  // Scoreboard: read data checked against queued expectations on each ack.
  always @(negedge clk) begin
    if (sb_en && cpu_ack_out) begin
      chk("ack_excl", dma_ack_out, 0);
      chk("cpu_q_nonempty", cpu_q.size() != 0, 1);
      if (cpu_q.size() != 0) chk("cpu_rdata", cpu_rdata_out, cpu_q.pop_front());
    end
    if (sb_en && dma_ack_out) begin
      chk("dma_q_nonempty", dma_q.size() != 0, 1);
      if (dma_q.size() != 0) chk("dma_rdata", dma_rdata_out, dma_q.pop_front());
    end
  end

  task automatic xfer(input vec_t v);
    if (v.dma) begin
      dma_we_in = v.we; dma_addr_in = v.addr; dma_wdata_in = v.wdata; dma_req_in = 1'b1;
      dma_q.push_back(v.exp);
    end else begin
      cpu_we_in = v.we; cpu_addr_in = v.addr; cpu_wdata_in = v.wdata; cpu_req_in = 1'b1;
      cpu_q.push_back(v.exp);
    end
    for (int k = 1; k <= 2 + MEM_LAT; k++) begin
      @(negedge clk);
      chk("owner_busy", owner_out, v.dma ? 2 : 1);
      if (k == 1) begin
        chk("en_first", mem_en_out, 1);
        chk("mem_we", mem_we_out, v.we);
        chk("mem_addr", mem_addr_out, v.addr);
        chk("mem_wdata", mem_wdata_out, v.wdata);
      end else begin
        chk("en_off", mem_en_out, 0);
      end
      if (k == 2 + MEM_LAT) begin
        chk("ack", v.dma ? dma_ack_out : cpu_ack_out, 1);
        chk("other_ack", v.dma ? cpu_ack_out : dma_ack_out, 0);
        cpu_req_in = 1'b0;
        dma_req_in = 1'b0;
      end else begin
        chk("no_ack", cpu_ack_out | dma_ack_out, 0);
      end
    end
    @(negedge clk);
    chk("owner_idle", owner_out, 0);
    chk("ack_clear", cpu_ack_out | dma_ack_out, 0);
  endtask

  initial begin
    int n, cyc, dmacnt, at[6];
    bit who[6];
    bit exp_dma[6];
    bit en_seen;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h12] = 16'hBEEF;
    mem[8'hFF] = 16'hC0DE;
    rst = 1'b1;
    cpu_req_in = 0; cpu_we_in = 0; cpu_addr_in = 0; cpu_wdata_in = 0;
    dma_req_in = 0; dma_we_in = 0; dma_addr_in = 0; dma_wdata_in = 0;

    tbl[0] = '{0, 0, 8'h12, 16'h0000, 16'hBEEF};
    tbl[1] = '{1, 1, 8'h40, 16'h1234, 16'h0000};
    tbl[2] = '{1, 0, 8'h40, 16'h0000, 16'h1234};
    tbl[3] = '{0, 1, 8'h12, 16'h5A5A, 16'hBEEF};
    tbl[4] = '{0, 0, 8'h12, 16'h0000, 16'h5A5A};
    tbl[5] = '{1, 0, 8'h12, 16'h0000, 16'h5A5A};
    tbl[6] = '{0, 0, 8'hFF, 16'h0000, 16'hC0DE};
    tbl[7] = '{1, 1, 8'hFF, 16'h0F0F, 16'h5A5A};
    tbl[8] = '{0, 0, 8'hFF, 16'h0000, 16'h0F0F};
    tbl[9] = '{1, 0, 8'h00, 16'h0000, 16'h0000};

    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cpu_ack", cpu_ack_out, 0);
    chk("rst_dma_ack", dma_ack_out, 0);
    chk("rst_mem_en", mem_en_out, 0);
    chk("rst_mem_we", mem_we_out, 0);
    chk("rst_mem_addr", mem_addr_out, 0);
    chk("rst_mem_wdata", mem_wdata_out, 0);
    chk("rst_owner", owner_out, 0);
    chk("rst_cpu_rdata", cpu_rdata_out, 0);
    chk("rst_dma_rdata", dma_rdata_out, 0);
    en_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      en_seen |= mem_en_out;
    end
    chk("idle_no_en", en_seen, 0);

    // Single transfers
    sb_en = 1'b1;
    for (int i = 0; i < 10; i++) xfer(tbl[i]);
    repeat (2) @(negedge clk);
    sb_en = 1'b0;
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dma_q_drained", dma_q.size(), 0);

    // Contention: both requests held
`ifdef MEM_ARB_STARVE_EN
    exp_dma = '{0, 0, 1, 0, 0, 1};
`else
    exp_dma = '{0, 0, 0, 0, 0, 0};
`endif
    cpu_we_in = 0; cpu_addr_in = 8'h12; cpu_req_in = 1'b1;
    dma_we_in = 0; dma_addr_in = 8'h40; dma_req_in = 1'b1;
    n = 0; cyc = 0; dmacnt = 0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 20 && dma_ack_out) dmacnt++;
      if (cpu_ack_out || dma_ack_out) begin
        chk("cont_excl", cpu_ack_out & dma_ack_out, 0);
        who[n] = dma_ack_out;
        at[n]  = cyc;
        chk("cont_rdata", dma_ack_out ? dma_rdata_out : cpu_rdata_out,
            dma_ack_out ? 16'h1234 : 16'h5A5A);
        n++;
        if (n == 6) begin
          cpu_req_in = 1'b0;
          dma_req_in = 1'b0;
        end
      end
    end
    cpu_req_in = 1'b0;
    dma_req_in = 1'b0;
    chk("cont_ack_count", n, 6);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("cont_winner%0d", i), who[i], exp_dma[i]);
      if (i == 0) chk("cont_first_lat", at[0], 2 + MEM_LAT);
      else chk($sformatf("cont_period%0d", i), at[i] - at[i-1], MEM_LAT + 3);
    end
`ifndef MEM_ARB_STARVE_EN
    chk("cont_dma_starved", dmacnt, 0);
`endif
    repeat (2) @(negedge clk);

    // Reset in the first ACC cycle abandons the access
    cpu_we_in = 0; cpu_addr_in = 8'h40; cpu_req_in = 1'b1;
    @(negedge clk);
    chk("mid_en", mem_en_out, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_owner", owner_out, 0);
    chk("mid_en_off", mem_en_out, 0);
    chk("mid_ack", cpu_ack_out | dma_ack_out, 0);
    chk("mid_rdata", cpu_rdata_out, 0);
    cyc = 0;
    while (!cpu_ack_out && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_regrant_lat", cyc, 2 + MEM_LAT);
    chk("mid_regrant_ack", cpu_ack_out, 1);
    chk("mid_regrant_rdata", cpu_rdata_out, 16'h1234);
    cpu_req_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_owner", owner_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
